// File: rtl/otter_pkg.sv
// Shared OTTER types: fetch queue entry and the decode bubble instruction.
package otter_pkg;

    // One fetched instruction paired with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0 -- inserted by decode when it needs a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a flush that wins over push/pop.
module fetch_fifo
    import otter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Storage needs no reset: entries are only visible once count says so.
    always_ff @(posedge CLK) begin
        if (push && !flush) r_mem[r_wptr] <= wdata;
    end

    // Pointers wrap naturally; count separates full from empty.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + PW'(1);
            if (pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER fetch front end: PC generator, credit-limited imem requests, {pc,instr} queue.
module otter_fetch_queue
    import otter_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc_plus4,
    output logic [CW-1:0]     fill_level
);

    logic [31:0] r_pc;
    logic        r_epoch;
    logic        r_inf;
    logic        r_inf_tag;
    logic [31:0] r_inf_pc;

    logic          w_deq;
    logic          w_push;
    logic [CW:0]   w_used;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wdata;
    logic          w_unused_rpc_lo;

    // Word alignment is forced, so the low redirect bits are never looked at.
    assign w_unused_rpc_lo = ^redirect_pc[1:0];

    assign out_valid = (w_count != '0);
    assign w_deq     = out_valid && out_ready;

    // Credits: queued + in flight, minus the slot freed by this cycle's deq.
    assign w_used   = {1'b0, w_count} + (CW+1)'(r_inf) - (CW+1)'(w_deq);
    assign mem_rden = RESET_N && !redirect_valid && (w_used < (CW+1)'(DEPTH));
    assign mem_addr = r_pc[ADDR_W+1:2];

    // Responses from a previous epoch belong to a squashed path.
    assign w_push  = r_inf && (r_inf_tag == r_epoch);
    assign w_wdata = '{pc: r_inf_pc, instr: mem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .flush   (redirect_valid),
        .push    (w_push),
        .wdata   (w_wdata),
        .pop     (w_deq),
        .rdata   (w_head),
        .count   (w_count)
    );

    // Empty queue presents zeros so downstream sees clean reset-like values.
    assign out_pc       = out_valid ? w_head.pc    : 32'h0;
    assign out_instr    = out_valid ? w_head.instr : 32'h0;
    assign out_pc_plus4 = out_pc + 32'd4;
    assign fill_level   = w_count;

    // PC advance, redirect and epoch/in-flight tracking.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pc      <= RESET_PC;
            r_epoch   <= 1'b0;
            r_inf     <= 1'b0;
            r_inf_tag <= 1'b0;
            r_inf_pc  <= 32'h0;
        end else if (redirect_valid) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_epoch <= ~r_epoch;
            r_inf   <= 1'b0;
        end else begin
            r_inf <= mem_rden;
            if (mem_rden) begin
                r_inf_tag <= r_epoch;
                r_inf_pc  <= r_pc;
                r_pc      <= r_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed + random bench for otter_fetch_queue against a queue-level reference model.
module tb_otter_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 14;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK;
    logic          RESET_N;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          mem_rden;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc_plus4;
    logic [CW-1:0] fill_level;

    otter_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .fill_level(fill_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memw(input logic [13:0] a);
        return {2'b10, a, 2'b01, ~a} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous instruction memory: data the cycle after the read enable.
    initial mem_rdata = 32'h0;
    always @(posedge CLK) if (mem_rden) mem_rdata <= memw(mem_addr);

    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t        q[$];
    logic [31:0] log_pc[$];
    logic [31:0] mpc, ipc;
    bit          inf;
    int          vec, errs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc = 32'h0;
        ipc = 32'h0;
        inf = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_rden",  32'(mem_rden), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc",    out_pc, 0);
        chk("rst_pc4",   out_pc_plus4, 4);
        chk("rst_fill",  32'(fill_level), 0);
    endtask

    // One clock: drive inputs, compare at negedge, advance the model at posedge.
    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit deq, rden;
        int used;
        out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        @(negedge CLK);
        deq  = (q.size() != 0) && rdy;
        used = q.size() + (inf ? 1 : 0) - (deq ? 1 : 0);
        rden = !rv && (used < DEPTH);
        chk("mem_rden",   32'(mem_rden), 32'(rden));
        chk("mem_addr",   32'(mem_addr), 32'(mpc[15:2]));
        chk("out_valid",  32'(out_valid), 32'(q.size() != 0));
        chk("fill_level", 32'(fill_level), 32'(q.size()));
        if (q.size() != 0) begin
            chk("out_pc",       out_pc, q[0].pc);
            chk("out_instr",    out_instr, q[0].ins);
            chk("out_pc_plus4", out_pc_plus4, q[0].pc + 32'd4);
        end
        if (deq) begin
            log_pc.push_back(q[0].pc);
            void'(q.pop_front());
        end
        if (rv) begin
            q.delete();
            mpc = {rpc[31:2], 2'b00};
            inf = 0;
        end else begin
            if (inf) q.push_back('{pc: ipc, ins: memw(ipc[15:2])});
            if (rden) begin
                ipc = mpc;
                mpc = mpc + 32'd4;
            end
            inf = rden;
        end
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic reset_pulse();
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        redirect_valid = 1'b0;
        RESET_N = 1'b1;
    endtask

    initial begin
        int n8, nc;
        vec = 0; errs = 0;
        RESET_N = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_vals();
        model_reset();
        RESET_N = 1'b1;

        // Streaming from reset: first output in cycle 2 at pc 0.
        repeat (2) cyc(1, 0, 0);
        chk("first_valid", 32'(out_valid), 1);
        chk("first_pc",    out_pc, 32'h0);
        repeat (6) cyc(1, 0, 0);

        // Back-pressure: saturate, then drain in order.
        reset_pulse();
        repeat (10) cyc(0, 0, 0);
        chk("stall_fill", 32'(fill_level), DEPTH);
        chk("stall_rden", 32'(mem_rden), 0);
        log_pc.delete();
        repeat (8) cyc(1, 0, 0);
        chk("drain_cnt", 32'(log_pc.size() >= 5), 1);
        for (int i = 0; i < 5 && i < log_pc.size(); i++)
            chk("drain_order", log_pc[i], 32'(i * 4));

        // Reset with a full queue, then redirect with 3 queued + 1 in flight.
        repeat (6) cyc(0, 0, 0);
        reset_pulse();
        repeat (4) cyc(0, 0, 0);
        chk("pre_redir_fill", 32'(fill_level), 3);
        cyc(0, 1, 32'h0000_0103);
        repeat (2) cyc(1, 0, 0);
        chk("redir_valid_t3", 32'(out_valid), 1);
        chk("redir_pc_t3",    out_pc, 32'h100);
        repeat (4) cyc(1, 0, 0);

        // Redirect in the same cycle that head 0x8 is consumed.
        reset_pulse();
        repeat (4) cyc(1, 0, 0);
        chk("head_8", out_pc, 32'h8);
        log_pc.delete();
        cyc(1, 1, 32'h0000_0200);
        repeat (6) cyc(1, 0, 0);
        n8 = 0; nc = 0;
        foreach (log_pc[i]) begin
            if (log_pc[i] == 32'h8) n8++;
            if (log_pc[i] == 32'hC) nc++;
        end
        chk("deq8_once", 32'(n8), 1);
        chk("no_0xC",    32'(nc), 0);

        // PC wrap at the top of the address space.
        cyc(1, 1, 32'hFFFF_FFFC);
        chk("wrap_addr_hi", 32'(mem_addr), 32'h3FFF);
        cyc(1, 0, 0);
        chk("wrap_addr_lo", 32'(mem_addr), 32'h0);
        repeat (5) cyc(1, 0, 0);

        // Random traffic with occasional redirects and resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) reset_pulse();
            else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                     ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                 : $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/otter_fetch_queue.md
# otter_fetch_queue

Parametrised instruction-fetch front end for the pipelined OTTER CPU. It replaces the free-running PC and bare fetch register with:
- a PC generator with redirect support;
- a credit-limited request port to the synchronous instruction-memory read port;
- a DEPTH-entry queue of {pc, instr} pairs, delivered to decode over a valid/ready handshake.

Redirects from execute (taken branch, JAL/JALR, trap) flush the queue and discard any in-flight memory response.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- ADDR_W, 14, instruction-memory word-address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- mem_rden  out  1  instruction-memory read enable
- mem_addr  out  ADDR_W  word address = pc[ADDR_W+1:2]
- mem_rdata  in  32  instruction word, valid the cycle after mem_rden
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_pc_plus4  out  32  head PC + 4
- fill_level  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- Reset values (asynchronous on RESET_N low):
  - pc = RESET_PC; queue empty; fill_level = 0; inflight = 0; epoch = 0.
  - mem_rden = 0; out_valid = 0; out_instr = 0; out_pc = 0; out_pc_plus4 = 4.
- Handshake:
  - A transfer (deq) occurs when out_valid && out_ready.
  - out_* hold stable while out_valid && !out_ready.
  - out_valid never depends combinationally on out_ready.
- Issue rule:
  - mem_rden = !redirect_valid && (fill_level + inflight − deq) < DEPTH.
  - On issue: the request is tagged with the current epoch, inflight is set, pc advances by 4.
  - pc is 32-bit and wraps modulo 2^32.
- Response:
  - A response is written into the queue in the cycle after issue, paired with its issue PC.
  - It is written only if its tag equals the current epoch; otherwise it is dropped.
- Redirect (redirect_valid = 1 in cycle t):
  - pc ← {redirect_pc[31:2], 2'b00}.
  - Queue cleared.
  - epoch toggles, so a response arriving in t+1 is dropped.
  - No issue in cycle t.
  - A deq in cycle t still completes for the consumer; the queue is cleared afterwards.
- Simultaneous enqueue and deq when full: both happen and occupancy stays DEPTH. The issue rule already prevents overflow.
- Deq while empty is impossible, because out_valid = 0.
- Queue pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by fill_level.

## Timing
- Fetch latency (no back-pressure):
  - issue in cycle t, mem_rdata in t+1, enqueued at the end of t+1, out_valid in t+2.
  - No memory-to-output bypass.
- First issue: the first cycle with RESET_N high.
- Redirect penalty: redirect in cycle t, issue of redirect_pc in t+1, out_valid with out_pc = redirect_pc in t+3.
- Throughput: one instruction per cycle sustained while out_ready = 1, for DEPTH ≥ 2.
- Reset asserted mid-operation: everything returns to its reset value immediately. Any response in the following cycle is ignored because inflight = 0.

## Structure
- Shared package otter_pkg gains:
  - typedef fetch_entry_t (packed: logic [31:0] pc; logic [31:0] instr);
  - localparam NOP_INSTR = 32'h0000_0013 for downstream bubble insertion.
- Sub-module fetch_fifo:
  - generic DEPTH × fetch_entry_t synchronous FIFO with async active-low reset;
  - ports: flush, push, pop, count.
- PC, epoch and credit logic live in otter_fetch_queue.

## Test plan
- Reset release with RESET_PC = 0, out_ready = 1 -> mem_rden high from cycle 0; out_valid in cycle 2 with out_pc = 0x0; pc values 0x0, 0x4, 0x8… on consecutive cycles; out_pc_plus4 = out_pc + 4.
- out_ready = 0 for 10 cycles, DEPTH = 4 -> fill_level saturates at 4; mem_rden drops; no entry lost or duplicated; releasing ready drains 0x0..0xC in order, then resumes at 0x10.
- redirect_valid with redirect_pc = 0x0000_0103 while 3 entries are queued and one is in flight -> queue empties; the in-flight word is dropped; next out_pc = 0x100 at t+3.
- Redirect in the same cycle as deq of head 0x8 -> 0x8 is consumed exactly once; no post-redirect output has pc 0xC.
- pc = 0xFFFF_FFFC fetch -> the following fetch is pc 0x0; mem_addr = pc[15:2].
- RESET_N pulsed low mid-stream with a full queue -> all outputs return to reset values asynchronously; refetch starts at RESET_PC.
